// File: rtl/temp_pkg.sv
// Shared definitions for the temperature sample scheduler: FSM state
// encoding, result data width, default timing constants and a helper that
// sizes terminal-count counters.
package temp_pkg;

  localparam int unsigned DATA_W      = 24;
  localparam int unsigned PERIOD_DEF  = 50_000_000;
  localparam int unsigned TIMEOUT_DEF = 100_000_000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    SEND      = 3'd3,
    WAIT_CONV = 3'd4,
    WAIT_PER  = 3'd5
  } state_e;

  // Counter width able to hold 0 .. limit-1 (at least one bit).
  function automatic int unsigned tmr_w(input int unsigned limit);
    if (limit > 32'd1) begin
      return $clog2(limit);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/sched_timer.sv
// Clearable up-counter that saturates at LIMIT-1 and flags the terminal
// count. Saturation lets the owner test "already reached" at any later time.
module sched_timer
  import temp_pkg::*;
#(
  parameter int unsigned LIMIT = PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned   W      = tmr_w(LIMIT);
  localparam logic [W-1:0]  TC_VAL = W'(LIMIT - 32'd1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear has priority, otherwise count up until terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/temp_sample_sched.sv
// Periodic temperature sample scheduler: starts the sensor driver every
// PERIOD cycles (or on trig), forwards the result to the BCD converter and
// counts completed samples.
// Optional feature macro: SAMPLE_TIMEOUT_EN -- abandons a sample whose
// sensor result does not arrive within TIMEOUT cycles and raises sticky err.
module temp_sample_sched
  import temp_pkg::*;
#(
  parameter int unsigned PERIOD  = PERIOD_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              trig,
  output logic              sens_start,
  input  logic              sens_done,
  input  logic              sens_sign,
  input  logic [DATA_W-1:0] sens_data,
  output logic              conv_sign,
  output logic [DATA_W-1:0] conv_din,
  output logic              conv_vld,
  input  logic              conv_dout_vld,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  sample_cnt
);

  state_e              state_q, state_d;
  logic                pend_q, pend_d;
  logic                conv_sign_q, conv_sign_d;
  logic [DATA_W-1:0]   conv_din_q, conv_din_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                start_q, start_d;
  logic                vld_q, vld_d;
  logic                busy_q, busy_d;
  logic                per_tc_s;
  logic                per_clr_s;
  logic                per_run_s;
  logic                tmo_tc_s;

  // Period counter restarts with every START so starts are PERIOD apart.
  assign per_clr_s = (state_d == START);
  assign per_run_s = (state_q != IDLE);

  sched_timer #(.LIMIT(PERIOD)) u_per_tmr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (per_clr_s),
    .en_i  (per_run_s),
    .tc_o  (per_tc_s)
  );

`ifdef SAMPLE_TIMEOUT_EN
  logic err_q, err_d;
  logic tmo_clr_s;

  // Timeout window covers only the cycles spent waiting for the sensor.
  assign tmo_clr_s = (state_q != WAIT_DONE);

  sched_timer #(.LIMIT(TIMEOUT)) u_tmo_tmr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmo_clr_s),
    .en_i  (1'b1),
    .tc_o  (tmo_tc_s)
  );

  // Sticky error: set when the sensor wait expires without a result.
  always_comb begin
    err_d = err_q;
    if ((state_q == WAIT_DONE) && !sens_done && tmo_tc_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_tc_s = 1'b0;
  assign err      = 1'b0;
`endif

  // Next-state logic and next values of the state-derived output pulses.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) state_d = START;
        else    state_d = IDLE;
      end
      START: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (sens_done)     state_d = SEND;
        else if (tmo_tc_s) state_d = WAIT_PER;
        else               state_d = WAIT_DONE;
      end
      SEND: state_d = WAIT_CONV;
      WAIT_CONV: begin
        if (conv_dout_vld) state_d = WAIT_PER;
        else               state_d = WAIT_CONV;
      end
      WAIT_PER: begin
        if (!en)                 state_d = IDLE;
        else if (trig || pend_q) state_d = START;
        else if (per_tc_s)       state_d = START;
        else                     state_d = WAIT_PER;
      end
      default: state_d = IDLE;
    endcase
    start_d = (state_d == START);
    vld_d   = (state_d == SEND);
    busy_d  = (state_d == START) || (state_d == WAIT_DONE) ||
              (state_d == SEND)  || (state_d == WAIT_CONV);
  end

  // Datapath: pending trigger, result capture and sample counter.
  always_comb begin
    pend_d      = pend_q;
    conv_sign_d = conv_sign_q;
    conv_din_d  = conv_din_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE:  pend_d = 1'b0;
      START: pend_d = trig;
      WAIT_DONE: begin
        pend_d = pend_q | trig;
        if (sens_done) begin
          conv_sign_d = sens_sign;
          conv_din_d  = sens_data;
        end else begin
          conv_sign_d = conv_sign_q;
          conv_din_d  = conv_din_q;
        end
      end
      SEND: pend_d = pend_q | trig;
      WAIT_CONV: begin
        pend_d = pend_q | trig;
        if (conv_dout_vld) cnt_d = cnt_q + CNT_W'(1'b1);
        else               cnt_d = cnt_q;
      end
      WAIT_PER: begin
        if (state_d == START) pend_d = 1'b0;
        else                  pend_d = pend_q;
      end
      default: pend_d = 1'b0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      conv_sign_q <= 1'b0;
      conv_din_q  <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      conv_sign_q <= conv_sign_d;
      conv_din_q  <= conv_din_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
    end
  end

  assign sens_start = start_q;
  assign conv_vld   = vld_q;
  assign busy       = busy_q;
  assign conv_sign  = conv_sign_q;
  assign conv_din   = conv_din_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_temp_sample_sched.sv
// Self-checking bench for temp_sample_sched (PERIOD=20, TIMEOUT=8, CNT_W=4).
// A transaction-level model predicts every output each cycle; directed
// scenarios add hand-computed expectations. Honours SAMPLE_TIMEOUT_EN.
module tb_temp_sample_sched;

  localparam int unsigned PERIOD  = 20;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DW      = 24;
`ifdef SAMPLE_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  localparam int P_OFF = 0, P_PULSE = 1, P_WAITRES = 2, P_SEND = 3, P_WAITCONV = 4, P_REST = 5;

  logic clk = 1'b0;
  logic rst, en, trig, sens_done, sens_sign, conv_dout_vld;
  logic [DW-1:0] sens_data;
  logic sens_start, conv_sign, conv_vld, busy, err;
  logic [DW-1:0] conv_din;
  logic [CNT_W-1:0] sample_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  temp_sample_sched #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .trig(trig),
    .sens_start(sens_start), .sens_done(sens_done), .sens_sign(sens_sign),
    .sens_data(sens_data), .conv_sign(conv_sign), .conv_din(conv_din),
    .conv_vld(conv_vld), .conv_dout_vld(conv_dout_vld), .busy(busy),
    .err(err), .sample_cnt(sample_cnt)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int          phase;
    bit          pend;
    int          start_cyc;
    int          cyc;
    bit          sign;
    logic [23:0] din;
    bit          err;
    int          cnt;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset(input mdl_t s);
    mdl_t n = s;
    n.phase = P_OFF; n.pend = 1'b0; n.sign = 1'b0; n.din = '0; n.err = 1'b0; n.cnt = 0;
    return n;
  endfunction

  // One clock of the sampling rules, expressed as elapsed time since the last start.
  function automatic mdl_t mdl_step(input mdl_t s);
    mdl_t n = s;
    case (s.phase)
      P_OFF:      if (en) n.phase = P_PULSE;
      P_PULSE:    n.phase = P_WAITRES;
      P_WAITRES: begin
        if (sens_done) begin
          n.sign = sens_sign; n.din = sens_data; n.phase = P_SEND;
        end else if (TMO_ON && (s.cyc - s.start_cyc >= int'(TIMEOUT))) begin
          n.err = 1'b1; n.phase = P_REST;
        end
      end
      P_SEND:     n.phase = P_WAITCONV;
      P_WAITCONV: if (conv_dout_vld) begin n.cnt = (s.cnt + 1) % (1 << CNT_W); n.phase = P_REST; end
      default: begin
        if (!en) n.phase = P_OFF;
        else if (trig || s.pend || (s.cyc - s.start_cyc >= int'(PERIOD) - 1)) n.phase = P_PULSE;
      end
    endcase
    if (n.phase == P_PULSE) begin
      n.pend = 1'b0; n.start_cyc = s.cyc + 1;
    end else if (s.phase == P_OFF) begin
      n.pend = 1'b0;
    end else if (s.phase != P_REST && trig) begin
      n.pend = 1'b1;
    end
    n.cyc = s.cyc + 1;
    return n;
  endfunction

  // Model state register.
  always @(posedge clk or posedge rst) begin
    if (rst) m <= mdl_reset(m);
    else     m <= mdl_step(m);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("sens_start", 32'(sens_start), 32'(m.phase == P_PULSE));
      chk("conv_vld",   32'(conv_vld),   32'(m.phase == P_SEND));
      chk("busy",       32'(busy),       32'(m.phase >= P_PULSE && m.phase <= P_WAITCONV));
      chk("err",        32'(err),        32'(m.err));
      chk("sample_cnt", 32'(sample_cnt), 32'(m.cnt));
      chk("conv_sign",  32'(conv_sign),  32'(m.sign));
      chk("conv_din",   32'(conv_din),   32'(m.din));
    end
  end

  // ---------------- stimulus ----------------
  int cyc = 0, done_tmr = 0, conv_tmr = 0, resp_delay = 2;
  int start_count = 0, vld_count = 0;
  bit no_resp = 1'b0, rnd_mode = 1'b0, spur = 1'b0;

  // Advance one cycle and play the sensor driver / converter responders.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    trig = 1'b0; sens_done = 1'b0; conv_dout_vld = 1'b0;
    if (done_tmr > 0) begin
      done_tmr--;
      if (done_tmr == 0) begin
        sens_done = 1'b1;
        if (rnd_mode) begin sens_data = DW'($urandom); sens_sign = 1'($urandom); end
      end
    end
    if (conv_tmr > 0) begin
      conv_tmr--;
      if (conv_tmr == 0) conv_dout_vld = 1'b1;
    end
    if (sens_start) begin
      start_count++;
      if (rnd_mode) begin
        resp_delay = $urandom_range(6, 1);
        no_resp = TMO_ON && ($urandom_range(7, 0) == 0);
      end
      done_tmr = no_resp ? 0 : resp_delay;
    end
    if (conv_vld) begin vld_count++; conv_tmr = 3; end
    if (spur && $urandom_range(31, 0) == 0) begin sens_done = 1'b1; sens_data = DW'($urandom); end
    if (spur && $urandom_range(31, 0) == 0) conv_dout_vld = 1'b1;
  endtask

  task automatic wait_for(input int sel, input int lim, input string nm, output int at);
    bit hit = 1'b0;
    at = -1;
    for (int i = 0; i < lim && !hit; i++) begin
      tick();
      case (sel)
        0: hit = sens_start;
        1: hit = conv_vld;
        2: hit = !busy;
        default: hit = err;
      endcase
    end
    if (hit) at = cyc;
    else begin
      checks++; errors++;
      $display("FAIL %s: event not seen within %0d cycles", nm, lim);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1; done_tmr = 0; conv_tmr = 0;
    tick();
    rst = 1'b0;
  endtask

  int t1, t2, t3, t4, t5, t6, t7, tc, te, e, sc, vc;

  initial begin
    rst = 1'b1; en = 1'b0; trig = 1'b0; sens_done = 1'b0; sens_sign = 1'b0;
    sens_data = '0; conv_dout_vld = 1'b0;
    tick();
    chk_on = 1'b1;
    tick();
    chk("rst_outputs", {25'd0, sens_start, conv_vld, busy, err, conv_sign, |conv_din, |sample_cnt}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("no_start_without_en", 32'(start_count), 32'd0);

    // First sample without period wait, result forwarded, second start 20 later.
    en = 1'b1; resp_delay = 2; sens_data = 24'd253125; sens_sign = 1'b0;
    wait_for(0, 3, "first_start", t1);
    wait_for(1, 10, "first_conv_vld", tc);
    chk("done_to_vld_latency", 32'(tc - t1), 32'd3);
    chk("conv_din_253125", 32'(conv_din), 32'd253125);
    chk("conv_sign_0", 32'(conv_sign), 32'd0);
    tick();
    chk("conv_vld_one_cycle", 32'(conv_vld), 32'd0);
    wait_for(2, 10, "first_wait_per", e);
    chk("sample_cnt_1", 32'(sample_cnt), 32'd1);
    wait_for(0, 30, "second_start", t2);
    chk("period_spacing", 32'(t2 - t1), 32'd20);

    // Trigger five cycles into the period wait.
    wait_for(2, 15, "wait_per_entry", e);
    for (int i = 0; i < 4; i++) tick();
    trig = 1'b1;
    tick();
    chk("trig_start", 32'(sens_start), 32'd1);
    t3 = cyc;
    wait_for(0, 30, "after_trig_start", t4);
    chk("spacing_after_trig", 32'(t4 - t3), 32'd20);

    // Trigger during the converter wait is held until the period wait.
    wait_for(1, 10, "vld_before_pend", tc);
    tick();
    trig = 1'b1;
    wait_for(0, 30, "pending_start", t5);
    chk("pending_start_offset", 32'(t5 - t4), 32'd8);

    // Sensor never answers.
    no_resp = 1'b1;
    wait_for(0, 30, "start_before_silence", t6);
    chk("spacing_before_silence", 32'(t6 - t5), 32'd20);
    vc = vld_count; sc = start_count;
`ifdef SAMPLE_TIMEOUT_EN
    wait_for(3, 20, "timeout_err", te);
    chk("timeout_err_cycle", 32'(te - t6), 32'd9);
    chk("no_vld_on_timeout", 32'(vld_count - vc), 32'd0);
    no_resp = 1'b0; resp_delay = 4;
    wait_for(0, 30, "start_after_timeout", t7);
    chk("spacing_after_timeout", 32'(t7 - t6), 32'd20);
`else
    for (int i = 0; i < 40; i++) tick();
    chk("no_timeout_err", 32'(err), 32'd0);
    chk("stuck_busy", 32'(busy), 32'd1);
    chk("stuck_no_start", 32'(start_count - sc), 32'd0);
    no_resp = 1'b0; resp_delay = 4;
    pulse_reset();
    wait_for(0, 3, "start_after_reset", t7);
`endif

    // en dropped mid-transaction: sample still completes, then idle.
    tick();
    en = 1'b0; sens_data = 24'h000001; sens_sign = 1'b0;
    wait_for(1, 10, "vld_after_en_low", tc);
    chk("conv_din_1", 32'(conv_din), 32'd1);
    sc = start_count;
    for (int i = 0; i < 100; i++) tick();
    chk("idle_no_start", 32'(start_count - sc), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);

    // Reset during converter wait.
    en = 1'b1; resp_delay = 2;
    wait_for(0, 3, "start_before_rst", t1);
    wait_for(1, 10, "vld_before_rst", tc);
    tick();
    rst = 1'b1; en = 1'b0;
    #1;
    chk("rst_immediate", {25'd0, sens_start, conv_vld, busy, err, conv_sign, |conv_din, |sample_cnt}, 32'd0);
    done_tmr = 0; conv_tmr = 0;
    tick(); tick();
    rst = 1'b0;
    sc = start_count;
    for (int i = 0; i < 10; i++) tick();
    chk("no_start_after_rst", 32'(start_count - sc), 32'd0);
    chk("sample_cnt_after_rst", 32'(sample_cnt), 32'd0);
    en = 1'b1;
    wait_for(0, 3, "start_after_en", t1);

    // Randomised operation checked cycle by cycle against the model.
    rnd_mode = 1'b1; spur = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      trig = ($urandom_range(15, 0) == 0);
      if (en && $urandom_range(299, 0) == 0) en = 1'b0;
      else if (!en && $urandom_range(19, 0) == 0) en = 1'b1;
      if ($urandom_range(999, 0) == 0) pulse_reset();
    end
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/temp_sample_sched.md
TEMP_SAMPLE_SCHED -- requirements
Module: temp_sample_sched

Interface
REQ-001 Parameter PERIOD, default 50_000_000, sets the clock cycles between successive sensor-sample starts.
REQ-002 Parameter TIMEOUT, default 100_000_000, sets the clock cycles allowed for sens_done after sens_start.
REQ-003 Parameter CNT_W, default 16, sets the width of sample_cnt.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 en  in  1  enables periodic sampling.
REQ-008 trig  in  1  one-shot request for an immediate sample.
REQ-009 sens_start  out  1  one-cycle start pulse to the sensor driver.
REQ-010 sens_done  in  1  one-cycle result strobe from the sensor driver.
REQ-011 sens_sign / sens_data  in  1 / 24  sensor result: sign, and magnitude x10000.
REQ-012 conv_sign / conv_din / conv_vld  out  1 / 24 / 1  feed to the BCD converter (converter latency is 3 cycles).
REQ-013 conv_dout_vld  in  1  converter output-valid strobe.
REQ-014 busy  out  1  a sample transaction is in flight.
REQ-015 err  out  1  sticky sensor-timeout flag.
REQ-016 sample_cnt  out  CNT_W  count of completed samples; wraps from max to 0.

Function
REQ-017 The FSM states SHALL be IDLE, START, WAIT_DONE, SEND, WAIT_CONV and WAIT_PER. All outputs are decoded from, or registered with, the state.
REQ-018 IDLE: en=1 -> START on the next cycle, so the first sample needs no period wait.
REQ-019 START: sens_start=1 for exactly one cycle, and the period counter is cleared to 0 -> WAIT_DONE.
REQ-020 WAIT_DONE: sens_done=1 -> capture sens_sign/sens_data into conv_sign/conv_din -> SEND. sens_done in cycle N gives conv_vld in cycle N+1.
REQ-021 SEND: conv_vld=1 for exactly one cycle -> WAIT_CONV. conv_sign/conv_din hold their value until the next capture.
REQ-022 WAIT_CONV: conv_dout_vld=1 -> sample_cnt increments by 1 -> WAIT_PER.
REQ-023 WAIT_PER: evaluated in priority order:
 - en=0 -> IDLE.
 - trig or pending trig -> START.
 - period counter reaches PERIOD-1 -> START.
REQ-024 The period counter SHALL run in all states except IDLE. If it has already reached PERIOD-1 on entry to WAIT_PER, START follows on the next cycle.
REQ-025 trig outside WAIT_PER and IDLE SHALL set a pending flag, serviced on WAIT_PER entry and cleared at START. trig in IDLE SHALL be ignored.
REQ-026 en=0 during START/WAIT_DONE/SEND/WAIT_CONV SHALL NOT abort the transaction; it completes, then IDLE.
REQ-027 busy=1 in START, WAIT_DONE, SEND and WAIT_CONV; otherwise 0.
REQ-028 sens_done outside WAIT_DONE and conv_dout_vld outside WAIT_CONV SHALL be ignored.

Reset
REQ-029 rst=1 SHALL immediately set the state to IDLE and set all of the following to 0:
 - outputs: sens_start, conv_sign, conv_din, conv_vld, busy, err, sample_cnt;
 - internal: both counters and the pending flag.
REQ-030 rst asserted mid-transaction SHALL discard the transaction with no further output pulses.

Configuration
REQ-031 Macro SAMPLE_TIMEOUT_EN defined: in WAIT_DONE a timeout counter reaches TIMEOUT-1 -> err<=1 (sticky until rst), no capture, no conv_vld -> WAIT_PER.
REQ-032 Macro SAMPLE_TIMEOUT_EN undefined: WAIT_DONE waits indefinitely, err is tied to 0, and no timeout counter is built.

Structure
REQ-033 Shared package temp_pkg SHALL hold:
 - the state encoding type;
 - DATA_W=24;
 - default PERIOD/TIMEOUT constants.
REQ-034 One sub-module, sched_timer, SHALL implement the clearable terminal-count counter; it is instantiated for the period counter and, under SAMPLE_TIMEOUT_EN, for the timeout counter.

Verification (PERIOD=20, TIMEOUT=8, macro defined unless noted)
REQ-035 en=1 after reset; sens_done 2 cycles after sens_start with sens_data=253125, sign=0 -> one-cycle conv_vld with conv_din=253125; after conv_dout_vld, sample_cnt=1; second sens_start exactly 20 cycles after the first.
REQ-036 trig pulse 5 cycles into WAIT_PER -> sens_start on the following cycle; later starts spaced 20 cycles from that start.
REQ-037 sens_done never asserted -> err=1 after 8 cycles in WAIT_DONE, no conv_vld, next sens_start 20 cycles after the failed one; same stimulus with the macro undefined -> FSM stays in WAIT_DONE and err=0.
REQ-038 en=0 during WAIT_DONE, then sens_done with data 24'h000001 -> conv_vld emitted, then IDLE, no further sens_start over 100 cycles.
REQ-039 trig during WAIT_CONV -> pending; sens_start one cycle after WAIT_PER entry.
REQ-040 rst asserted in WAIT_CONV -> all outputs 0 in the same cycle and sample_cnt=0; no sens_start until en is seen high after rst is released.
